gpioemu_master: RTL

GPIOEMU_MASTER -- requirements
Module: gpioemu_master

---
 rtl/gpioemu_pkg.sv | 24 ++
 rtl/gpioemu_master_if.sv | 11 +
 rtl/gpioemu_bus_if.sv | 42 ++++
 rtl/gpioemu_master.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/gpioemu_pkg.sv
// Shared constants, state/access enums and helpers for the GPIO-emulated multiplier master.
package gpioemu_pkg;

  localparam logic [15:0] ADDR_OP_A   = 16'h037F;
  localparam logic [15:0] ADDR_OP_B   = 16'h0388;
  localparam logic [15:0] ADDR_GO     = 16'h03A1;
  localparam logic [15:0] ADDR_STATUS = 16'h03A0;
  localparam logic [15:0] ADDR_RES_W  = 16'h0390;
  localparam logic [15:0] ADDR_RES_L  = 16'h0398;

  typedef enum logic [3:0] {
    IDLE, WR_A1, WR_A2, WR_GO, SETTLE, POLL, RD_W, RD_L, FIN
  } state_t;

  typedef enum logic { RD, WR } acc_t;

  function automatic logic [23:0] popcount32(input logic [31:0] v);
    logic [23:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 24'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/gpioemu_master_if.sv
// Peripheral register bus: 16-bit address, separate read/write strobes, 32-bit data each way.
interface gpioemu_master_if;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_out;
  logic [31:0] sdata_in;

  modport master (output saddress, srd, swr, sdata_out, input sdata_in);
  modport slave  (input saddress, srd, swr, sdata_out, output sdata_in);
endinterface

// File: rtl/gpioemu_bus_if.sv
// Single register access: setup cycle, STROBE_CYCLES strobe cycles, hold cycle; ack marks the hold cycle.
module gpioemu_bus_if
  import gpioemu_pkg::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              req,
  input  acc_t              acc_type,
  input  logic [15:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic [31:0]       rdata,
  gpioemu_master_if.master  bus
);

  localparam logic [4:0] STROBE_LAST = 5'(STROBE_CYCLES);
  localparam logic [4:0] HOLD_CNT    = 5'(STROBE_CYCLES + 1);

  logic [4:0] cnt;
  logic       strobe;

  // req is held by the sequencer for the whole access, so address/data stay stable through hold
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)         cnt <= '0;
    else if (!req || ack) cnt <= '0;
    else                  cnt <= cnt + 5'd1;
  end

  assign ack    = req && (cnt == HOLD_CNT);
  assign strobe = req && (cnt != 5'd0) && (cnt <= STROBE_LAST);

  assign bus.srd       = strobe && (acc_type == RD);
  assign bus.swr       = strobe && (acc_type == WR);
  assign bus.saddress  = req ? addr : '0;
  assign bus.sdata_out = (req && acc_type == WR) ? wdata : '0;

  // Sequencer captures this on the edge that ends the hold cycle
  assign rdata = bus.sdata_in;

endmodule

// File: rtl/gpioemu_master.sv
// Sequences operand writes, start, status polling and result reads of the multiplier peripheral.
// Optional poll timeout enabled by defining GPIOEMU_MASTER_TIMEOUT_EN.
module gpioemu_master
  import gpioemu_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int POLL_LIMIT    = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic [23:0]       op_a,
  input  logic [23:0]       op_b,
  output logic              busy,
  output logic              done,
  output logic [31:0]       res_w,
  output logic [23:0]       res_l,
  output logic              res_valid,
  output logic              err_timeout,
  output logic              err_popcnt,
  gpioemu_master_if.master  bus
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [23:0] a_q, b_q;
  logic [15:0] settle_cnt;
  logic        gap;
  logic        req, ack, timeout_hit;
  acc_t        acc_type;
  logic [15:0] addr;
  logic [31:0] wdata, rdata;

  gpioemu_bus_if #(.STROBE_CYCLES(STROBE_CYCLES)) u_bus (
    .clk(clk), .n_reset(n_reset), .req(req), .acc_type(acc_type), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .bus(bus)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    acc_type  = WR;
    addr      = '0;
    wdata     = '0;
    case (state)
      IDLE:   if (start) state_nxt = WR_A1;
      WR_A1: begin
        req = 1'b1; addr = ADDR_OP_A; wdata = {8'h0, a_q};
        if (ack) state_nxt = WR_A2;
      end
      WR_A2: begin
        req = 1'b1; addr = ADDR_OP_B; wdata = {8'h0, b_q};
        if (ack) state_nxt = WR_GO;
      end
      WR_GO: begin
        req = 1'b1; addr = ADDR_GO;
        if (ack) state_nxt = SETTLE;
      end
      SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = POLL;
      POLL: begin
        // gap forces one idle cycle between consecutive status reads
        req = !gap; acc_type = RD; addr = ADDR_STATUS;
        if (ack) begin
          if (rdata[1])         state_nxt = RD_W;
          else if (timeout_hit) state_nxt = FIN;
        end
      end
      RD_W: begin
        req = 1'b1; acc_type = RD; addr = ADDR_RES_W;
        if (ack) state_nxt = RD_L;
      end
      RD_L: begin
        req = 1'b1; acc_type = RD; addr = ADDR_RES_L;
        if (ack) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE) && (state != FIN);
  assign done = (state == FIN);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a_q        <= '0;
      b_q        <= '0;
      settle_cnt <= '0;
      gap        <= 1'b0;
      res_w      <= '0;
      res_l      <= '0;
      res_valid  <= 1'b0;
      err_popcnt <= 1'b0;
    end else begin
      settle_cnt <= (state == SETTLE) ? settle_cnt + 16'd1 : '0;
      gap        <= (state == POLL) && ack && !rdata[1];
      if (state == IDLE && start) begin
        a_q        <= op_a;
        b_q        <= op_b;
        res_w      <= '0;
        res_l      <= '0;
        res_valid  <= 1'b0;
        err_popcnt <= 1'b0;
      end
      if (ack) begin
        case (state)
          POLL: if (rdata[1]) res_valid <= rdata[0];
          RD_W: res_w <= rdata;
          RD_L: begin
            res_l      <= rdata[23:0];
            err_popcnt <= (popcount32(res_w) != rdata[23:0]);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef GPIOEMU_MASTER_TIMEOUT_EN
  localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);
  logic [15:0] poll_cnt;

  assign timeout_hit = (poll_cnt == POLL_LAST);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      poll_cnt    <= '0;
      err_timeout <= 1'b0;
    end else if (state == IDLE) begin
      poll_cnt <= '0;
      if (start) err_timeout <= 1'b0;
    end else if (state == POLL && ack && !rdata[1]) begin
      poll_cnt <= poll_cnt + 16'd1;
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
